// File: rtl/gbt_tx_frame_sched_pkg.sv
// Shared types and constants for the GBT elink frame scheduler.
// Optional CRC trailer build: GBT_TX_FRAME_CRC_EN.
package gbt_tx_frame_sched_pkg;

  // Encoding is word index + 1, so IDLE sits at zero.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4,
    ST_W4   = 3'd5,
    ST_W5   = 3'd6,
    ST_W6   = 3'd7
  } state_t;

  localparam logic [2:0] WORD_W0 = 3'd0;
  localparam logic [2:0] WORD_W1 = 3'd1;
  localparam logic [2:0] WORD_W2 = 3'd2;
  localparam logic [2:0] WORD_W3 = 3'd3;
  localparam logic [2:0] WORD_W4 = 3'd4;
  localparam logic [2:0] WORD_W5 = 3'd5;
  localparam logic [2:0] WORD_W6 = 3'd6;

  localparam logic [11:0] FRAME_END_DEF = 12'hABC;
  localparam logic [11:0] IDLE_WORD_DEF = 12'h000;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [3:0] CRC_TAG   = 4'hA;

  function automatic logic [11:0] frame_payload(input logic [2:0]  idx,
                                                input logic        src,
                                                input logic [31:0] addr,
                                                input logic [31:0] data,
                                                input logic [11:0] end_pl);
    logic [11:0] pl;
    case (idx)
      WORD_W0: pl = {1'b1, src, 2'b00, addr[31:24]};
      WORD_W1: pl = addr[23:12];
      WORD_W2: pl = addr[11:0];
      WORD_W3: pl = {4'h0, data[31:24]};
      WORD_W4: pl = data[23:12];
      WORD_W5: pl = data[11:0];
      default: pl = end_pl;
    endcase
    return pl;
  endfunction

  // MSB-first CRC-8 over {addr, data}, init 0x00.
  function automatic logic [11:0] crc_end_payload(input logic [63:0] msg);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      if (crc[7] ^ msg[i]) crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      else                 crc = {crc[6:0], 1'b0};
    end
    return {CRC_TAG, crc};
  endfunction

endpackage

// File: rtl/gbt_tx_frame_sched_rr_arb.sv
// Two-way round-robin arbiter; grant is combinational, priority flips to the loser after each grant.
module gbt_tx_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       slot_open,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (slot_open) begin
      if (req[0] && (!prio || !req[1])) grant = 2'b01;
      else if (req[1])                  grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= 1'b0;
    else if (|grant) prio <= grant[0];
  end

endmodule

// File: rtl/gbt_tx_frame_sched.sv
// Seven-word GBT elink frame scheduler for two requesters, one word per 40 MHz cycle.
// Build with GBT_TX_FRAME_CRC_EN to replace the end marker by a CRC-8 trailer.
module gbt_tx_frame_sched
  import gbt_tx_frame_sched_pkg::*;
#(
  parameter logic [11:0] FRAME_END = FRAME_END_DEF,
  parameter logic [11:0] IDLE_WORD = IDLE_WORD_DEF
) (
  input  logic             ttc_clk_40_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic [3:0]       aux_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][31:0] req_data_i,
  output logic [15:0]      gbt_tx_data_o,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o
);

  state_t      state;
  logic        armed;
  logic        slot_open;
  logic [1:0]  grant;
  logic        grant_src;
  logic        src_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] frame_cnt;
  logic [11:0] end_payload;
  logic [2:0]  nxt_idx;

`ifdef GBT_TX_FRAME_CRC_EN
  logic [11:0] crc_pl_q;
  assign end_payload = crc_pl_q;
`else
  assign end_payload = FRAME_END;
`endif

  // armed keeps the first edge after reset release an idle word.
  assign slot_open   = armed && en_i && (state == ST_IDLE || state == ST_W6);
  assign grant_src   = grant[1];
  assign req_ready_o = grant;
  assign frame_cnt_o = frame_cnt;
  // With the word-index+1 encoding, the current code is the next word's index.
  assign nxt_idx     = state;

  gbt_tx_rr_arb u_arb (
    .clk       (ttc_clk_40_i),
    .rst_n     (reset_n_i),
    .req       (req_valid_i),
    .slot_open (slot_open),
    .grant     (grant)
  );

  always_ff @(posedge ttc_clk_40_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= ST_IDLE;
      armed         <= 1'b0;
      gbt_tx_data_o <= 16'h0000;
      busy_o        <= 1'b0;
      frame_cnt     <= 16'h0000;
      src_q         <= 1'b0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
`ifdef GBT_TX_FRAME_CRC_EN
      crc_pl_q      <= 12'h000;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE, ST_W6: begin
          if (state == ST_W6) frame_cnt <= frame_cnt + 16'd1;
          if (|grant) begin
            state         <= ST_W0;
            busy_o        <= 1'b1;
            src_q         <= grant_src;
            addr_q        <= req_addr_i[grant_src];
            data_q        <= req_data_i[grant_src];
            gbt_tx_data_o <= {aux_i, frame_payload(WORD_W0, grant_src, req_addr_i[grant_src],
                                                   req_data_i[grant_src], end_payload)};
`ifdef GBT_TX_FRAME_CRC_EN
            crc_pl_q      <= crc_end_payload({req_addr_i[grant_src], req_data_i[grant_src]});
`endif
          end else begin
            state         <= ST_IDLE;
            busy_o        <= 1'b0;
            gbt_tx_data_o <= {aux_i, IDLE_WORD};
          end
        end
        default: begin
          state         <= state_t'(state + 3'd1);
          busy_o        <= 1'b1;
          gbt_tx_data_o <= {aux_i, frame_payload(nxt_idx, src_q, addr_q, data_q, end_payload)};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbt_tx_frame_sched.sv
// Scoreboard bench for gbt_tx_frame_sched: randomized requests against a frame-level model.
`timescale 1ns/1ps
module tb_gbt_tx_frame_sched;

  localparam logic [11:0] FRAME_END = 12'hABC;
  localparam logic [11:0] IDLE_WORD = 12'h000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic [3:0]       aux = 4'h0;
  logic [1:0]       valid = 2'b00;
  logic [1:0]       ready;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] data = '0;
  logic [15:0]      tx;
  logic             busy;
  logic [15:0]      cnt;

  gbt_tx_frame_sched #(.FRAME_END(FRAME_END), .IDLE_WORD(IDLE_WORD)) dut (
    .ttc_clk_40_i  (clk),
    .reset_n_i     (rst_n),
    .en_i          (en),
    .aux_i         (aux),
    .req_valid_i   (valid),
    .req_ready_o   (ready),
    .req_addr_i    (addr),
    .req_data_i    (data),
    .gbt_tx_data_o (tx),
    .busy_o        (busy),
    .frame_cnt_o   (cnt)
  );

  always #12 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [12:0] exp_q[$];      // {last_word, payload}
  logic [15:0] exp_cnt = 16'h0;
  logic [3:0]  aux_last = 4'h0;
  logic        prio_m = 1'b0;
  bit          pending [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_data [2];
  logic [12:0] mon_e;

  always @(posedge clk) aux_last = aux;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Polynomial long division of {msg, 8'h00} by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input logic [63:0] msg);
    logic [71:0] m;
    m = {msg, 8'h00};
    for (int i = 71; i >= 8; i--)
      if (m[i]) m = m ^ (72'h107 << (i - 8));
    return m[7:0];
  endfunction

  function automatic void push_frame(input logic s, input logic [31:0] a, input logic [31:0] d);
    logic [11:0] last;
`ifdef GBT_TX_FRAME_CRC_EN
    last = {4'hA, crc_model({a, d})};
`else
    last = FRAME_END;
`endif
    exp_q.push_back({1'b0, 1'b1, s, 2'b00, a[31:24]});
    exp_q.push_back({1'b0, a[23:12]});
    exp_q.push_back({1'b0, a[11:0]});
    exp_q.push_back({1'b0, 4'h0, d[31:24]});
    exp_q.push_back({1'b0, d[23:12]});
    exp_q.push_back({1'b0, d[11:0]});
    exp_q.push_back({1'b1, last});
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_tx", 32'(tx), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cnt", 32'(cnt), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
    end else begin
      check("frame_cnt", 32'(cnt), 32'(exp_cnt));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("frame_word", 32'(tx), 32'({aux_last, mon_e[11:0]}));
        check("busy_frame", 32'(busy), 32'h1);
        if (mon_e[12]) exp_cnt = exp_cnt + 16'd1;
      end else begin
        check("idle_word", 32'(tx), 32'({aux_last, IDLE_WORD}));
        check("busy_idle", 32'(busy), 32'h0);
      end
    end
  end

  // One cycle: update requests at the falling edge, then predict and check the grant.
  task automatic step(input int p_new, input int p_cancel, input logic en_v);
    logic [1:0] exp_rdy;
    logic       pick;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!pending[i] && $urandom_range(99) < p_new) begin
        pending[i] = 1'b1;
        p_addr[i]  = $urandom;
        p_data[i]  = $urandom;
      end else if (pending[i] && $urandom_range(99) < p_cancel) begin
        pending[i] = 1'b0;
      end
      valid[i] = pending[i];
      addr[i]  = pending[i] ? p_addr[i] : $urandom;
      data[i]  = pending[i] ? p_data[i] : $urandom;
    end
    en  = en_v;
    aux = 4'($urandom);
    #2;
    exp_rdy = 2'b00;
    pick    = 1'b0;
    if (exp_q.size() == 0 && en_v && (pending[0] || pending[1])) begin
      pick = pending[prio_m] ? prio_m : !prio_m;
      exp_rdy[pick] = 1'b1;
    end
    check("req_ready", 32'(ready), 32'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      push_frame(pick, p_addr[pick], p_data[pick]);
      pending[pick] = 1'b0;
      prio_m = !pick;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    valid = 2'b00;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    exp_q.delete();
    exp_cnt = 16'h0;
    prio_m  = 1'b0;
    #1;
    check("async_tx", 32'(tx), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_cnt", 32'(cnt), 32'h0);
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || pending[0] || pending[1]) && guard < 40) begin
      step(0, 100, 1'b0);
      guard++;
    end
    if (guard >= 40) timeout("drain");
    step(0, 100, 1'b0);
  endtask

  initial begin
    int guard;
    #5;
    do_reset(3);

    // Single request from requester 0 with the reference address/data.
    pending[0] = 1'b1;
    p_addr[0]  = 32'h40000000;
    p_data[0]  = 32'h12345678;
    step(0, 0, 1'b1);
    drain();

    // Reset pulse while W4 is on the line, then a fresh frame.
    pending[1] = 1'b1;
    p_addr[1]  = $urandom;
    p_data[1]  = $urandom;
    step(0, 0, 1'b1);
    guard = 0;
    while (exp_q.size() != 2 && guard < 20) begin
      step(0, 0, 1'b1);
      guard++;
    end
    if (guard >= 20) timeout("reach_w4");
    do_reset(2);
    pending[0] = 1'b1;
    p_addr[0]  = $urandom;
    p_data[0]  = $urandom;
    step(0, 0, 1'b1);
    drain();

    // Both requesters always valid: alternating grants, no gaps.
    do_reset(1);
    repeat (22) step(100, 0, 1'b1);

    // Drop enable while W2 is on the line, hold it low, then resume.
    guard = 0;
    while (exp_q.size() != 4 && guard < 20) begin
      step(100, 0, 1'b1);
      guard++;
    end
    if (guard >= 20) timeout("reach_w2");
    repeat (12) step(100, 0, 1'b0);
    repeat (10) step(100, 0, 1'b1);
    drain();

`ifdef GBT_TX_FRAME_CRC_EN
    pending[0] = 1'b1;
    p_addr[0]  = 32'h0;
    p_data[0]  = 32'h1;
    step(0, 0, 1'b1);
    drain();
`endif

    // Counter wrap from a preloaded 16'hFFFF.
    @(negedge clk);
    #2;
    force dut.frame_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.frame_cnt;
    pending[1] = 1'b1;
    p_addr[1]  = $urandom;
    p_data[1]  = $urandom;
    step(0, 0, 1'b1);
    drain();
    check("cnt_wrap", 32'(cnt), 32'h0);

    // Randomized traffic with random enable and cancellations.
    for (int n = 0; n < 1500; n++)
      step(30, 10, 1'($urandom_range(99) < 85));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
